// File: rtl/z80_bus_master.sv
// z80_bus_master
//   Bus initiator that turns single-beat host read/write requests into
//   Z80-style bus cycles (T1, T2, optional wait states TW, T3) on the system
//   bus. The slave stretches a cycle by holding ibus_mwait low; if it holds it
//   for TIMEOUT wait states the cycle is aborted and completes with rsp_err=1.
//
//   Host handshake: a request transfers on a clk edge where ena, req_valid and
//   req_ready are all 1. req_ready is 1 exactly while the FSM is IDLE, also in
//   the cycle that carries rsp_valid, so back-to-back requests need no gap.
//   req_* is sampled only on the transfer edge. rsp_valid is a one-ena-cycle
//   pulse with no back-pressure.
//
// Ports
//   clk, rstn, ena                 clock, async active-low reset, clock enable
//   req_valid/req_ready            host request handshake
//   req_we, req_addr, req_wdata    request: 1=write, address, write data
//   rsp_valid, rsp_rdata, rsp_err  completion pulse, read data, timeout abort
//   obus_addr, obus_dmaster        bus address and master data
//   obus_rdn, obus_wrn             active-low read/write strobes (registered)
//   obus_mreqn, obus_iorqn,
//   obus_m1n                       other bus strobes, held inactive (1)
//   ibus_mwait, ibus_dslave        slave wait (active low) and read data
//   dbg_state                      current FSM state (0 IDLE,1 T1,2 T2,3 TW,4 T3)
module z80_bus_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ena,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] obus_addr,
  output logic [DATA_W-1:0] obus_dmaster,
  output logic              obus_rdn,
  output logic              obus_wrn,
  output logic              obus_mreqn,
  output logic              obus_iorqn,
  output logic              obus_m1n,
  input  logic              ibus_mwait,
  input  logic [DATA_W-1:0] ibus_dslave,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic              w_to_hit;
  logic              w_strobe_next;
  logic              r_we;
  logic              r_abort;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dmaster;
  logic              r_rdn;
  logic              r_wrn;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  always_comb begin
    w_next   = r_state;
    w_to_hit = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = ibus_mwait ? S_T3 : S_TW;
      S_TW: begin
        if (ibus_mwait) begin
          w_next = S_T3;
        end else if (r_cnt == TO_LIMIT) begin
          w_next   = S_T3;
          w_to_hit = 1'b1;
        end
      end
      S_T3:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they only ever change on a
  // clk edge; they are low for exactly the T2/TW/T3 states.
  assign w_strobe_next = (w_next == S_T2) || (w_next == S_TW) || (w_next == S_T3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_abort     <= 1'b0;
      r_cnt       <= 16'd0;
      r_addr      <= '0;
      r_dmaster   <= '0;
      r_rdn       <= 1'b1;
      r_wrn       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (ena) begin
      r_state     <= w_next;
      r_rdn       <= !(w_strobe_next && !r_we);
      r_wrn       <= !(w_strobe_next && r_we);
      // Completion pulse lasts one ena cycle; T3 re-arms it below.
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_abort <= 1'b0;
            if (req_we) r_dmaster <= req_wdata;
          end
        end
        S_T2: if (!ibus_mwait) r_cnt <= 16'd1;
        S_TW: begin
          if (w_to_hit) r_abort <= 1'b1;
          else if (!ibus_mwait && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end
        S_T3: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_abort;
          r_rsp_rdata <= (!r_we && !r_abort) ? ibus_dslave : '0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign obus_addr    = r_addr;
  assign obus_dmaster = r_dmaster;
  assign obus_rdn     = r_rdn;
  assign obus_wrn     = r_wrn;
  assign obus_mreqn   = 1'b1;
  assign obus_iorqn   = 1'b1;
  assign obus_m1n     = 1'b1;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master with a small RAM-like slave model whose
// wait-state behaviour is set by wait_n (wait states per cycle) and stuck
// (mwait never released). Built with TIMEOUT=4.
module tb_z80_bus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ena = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] obus_addr;
  logic [7:0]  obus_dmaster;
  logic        obus_rdn, obus_wrn, obus_mreqn, obus_iorqn, obus_m1n;
  logic        ibus_mwait;
  logic [7:0]  ibus_dslave;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  z80_bus_master #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .obus_addr(obus_addr), .obus_dmaster(obus_dmaster),
    .obus_rdn(obus_rdn), .obus_wrn(obus_wrn),
    .obus_mreqn(obus_mreqn), .obus_iorqn(obus_iorqn), .obus_m1n(obus_m1n),
    .ibus_mwait(ibus_mwait), .ibus_dslave(ibus_dslave),
    .dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  logic [7:0] mem [0:255];
  int  wait_n  = 0;
  bit  stuck   = 1'b0;
  int  low_cnt = 0;

  assign ibus_dslave = mem[obus_addr[7:0]];
  assign ibus_mwait  = !(stuck || ((!obus_rdn || !obus_wrn) && (low_cnt < wait_n)));

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h34] <= 8'hA5;
    end else if (ena) begin
      if (!obus_wrn) mem[obus_addr[7:0]] <= obus_dmaster;
      if (!obus_rdn || !obus_wrn) low_cnt <= low_cnt + 1;
      else                        low_cnt <= 0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // One request starting in IDLE at a cycle boundary. lat counts ena edges from
  // the acceptance edge up to and including the edge that raises rsp_valid.
  task automatic xact(input logic we, input logic [15:0] a, input logic [7:0] wd,
                      input bit tog, output int lat, output int rd_low,
                      output int wr_low, output logic err, output logic [7:0] rdata);
    logic        was_ena, rd0, wr0, rv0;
    logic [2:0]  st0;
    logic [15:0] ad0;
    bit          done;
    lat = 0; rd_low = 0; wr_low = 0; err = 1'b0; rdata = 8'h00; done = 1'b0;
    req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1; ena = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      was_ena = ena; st0 = dbg_state; rd0 = obus_rdn; wr0 = obus_wrn;
      ad0 = obus_addr; rv0 = rsp_valid;
      if (was_ena && !rd0) rd_low++;
      if (was_ena && !wr0) wr_low++;
      step();
      if (c == 0) begin
        // Scrambled after acceptance; the cycle in flight must ignore this.
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd;
      end
      if (was_ena) lat++;
      else begin
        check("frz_state", 32'(dbg_state), 32'(st0));
        check("frz_rdn", 32'(obus_rdn), 32'(rd0));
        check("frz_wrn", 32'(obus_wrn), 32'(wr0));
        check("frz_addr", 32'(obus_addr), 32'(ad0));
        check("frz_rsp_valid", 32'(rsp_valid), 32'(rv0));
      end
      check("no_rd_wr_overlap", 32'(obus_rdn | obus_wrn), 32'd1);
      if (rsp_valid) begin
        done = 1'b1; err = rsp_err; rdata = rsp_rdata;
      end else if (tog) begin
        ena = ~ena;
      end
    end
    if (!done) check("rsp_wait_bound", 32'd0, 32'd1);
    ena = 1'b1;
  endtask

  // The cycle after a completion: pulse must be gone, error cleared.
  task automatic after_rsp(input string tag);
    step();
    check({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
    check({tag, "_err_clr"}, 32'(rsp_err), 32'd0);
  endtask

  int         lat, rdl, wrl;
  logic       err;
  logic [7:0] rd;
  bit         seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rdn", 32'(obus_rdn), 32'd1);
    check("rst_wrn", 32'(obus_wrn), 32'd1);
    check("rst_addr", 32'(obus_addr), 32'd0);
    check("rst_dmaster", 32'(obus_dmaster), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_other_strobes", 32'({obus_mreqn, obus_iorqn, obus_m1n}), 32'd7);
    rstn = 1'b1; ena = 1'b1;
    step();

    // ---------------- 1: plain read ----------------
    xact(1'b0, 16'h1234, 8'h00, 1'b0, lat, rdl, wrl, err, rd);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_rdata", 32'(rd), 32'hA5);
    check("t1_err", 32'(err), 32'd0);
    check("t1_rdn_low", 32'(rdl), 32'd2);
    check("t1_wrn_low", 32'(wrl), 32'd0);
    after_rsp("t1");

    // ---------------- 2: write then read back ----------------
    xact(1'b1, 16'h00FF, 8'h3C, 1'b0, lat, rdl, wrl, err, rd);
    check("t2w_latency", 32'(lat), 32'd4);
    check("t2w_wrn_low", 32'(wrl), 32'd2);
    check("t2w_rdn_low", 32'(rdl), 32'd0);
    check("t2w_rdata_zero", 32'(rd), 32'd0);
    check("t2w_err", 32'(err), 32'd0);
    check("t2w_addr_held", 32'(obus_addr), 32'h00FF);
    check("t2w_dmaster_held", 32'(obus_dmaster), 32'h3C);
    after_rsp("t2w");
    xact(1'b0, 16'h00FF, 8'h00, 1'b0, lat, rdl, wrl, err, rd);
    check("t2r_rdata", 32'(rd), 32'h3C);
    check("t2r_latency", 32'(lat), 32'd4);
    after_rsp("t2r");

    // ---------------- 3: three wait states ----------------
    wait_n = 3;
    xact(1'b0, 16'h1234, 8'h00, 1'b0, lat, rdl, wrl, err, rd);
    check("t3_latency", 32'(lat), 32'd7);
    check("t3_rdata", 32'(rd), 32'hA5);
    check("t3_err", 32'(err), 32'd0);
    check("t3_rdn_low", 32'(rdl), 32'd5);
    wait_n = 0;
    after_rsp("t3");

    // ---------------- 6: ena toggling ----------------
    xact(1'b0, 16'h1234, 8'h00, 1'b1, lat, rdl, wrl, err, rd);
    check("t6_ena_latency", 32'(lat), 32'd4);
    check("t6_rdata", 32'(rd), 32'hA5);
    check("t6_rdn_low", 32'(rdl), 32'd2);
    after_rsp("t6");

    // ---------------- 7: back-to-back ----------------
    req_we = 1'b0; req_addr = 16'h1234; req_valid = 1'b1; ena = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) req_addr = 16'h00FF;
      if (c == 4) begin
        check("t7_rsp1_valid", 32'(rsp_valid), 32'd1);
        check("t7_rsp1_rdata", 32'(rsp_rdata), 32'hA5);
        check("t7_ready_on_rsp", 32'(req_ready), 32'd1);
      end
      if (c == 5) begin
        check("t7_no_gap_t1", 32'(dbg_state), 32'd1);
        check("t7_rsp1_end", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
      end
      if (c == 8) begin
        check("t7_rsp2_valid", 32'(rsp_valid), 32'd1);
        check("t7_rsp2_rdata", 32'(rsp_rdata), 32'h3C);
      end
    end

    // ---------------- 4: timeout abort ----------------
    stuck = 1'b1;
    xact(1'b0, 16'h1234, 8'h00, 1'b0, lat, rdl, wrl, err, rd);
    check("t4_latency", 32'(lat), 32'd8);
    check("t4_err", 32'(err), 32'd1);
    check("t4_rdata_zero", 32'(rd), 32'd0);
    check("t4_rdn_low", 32'(rdl), 32'd6);
    check("t4_strobes_up", 32'({obus_rdn, obus_wrn}), 32'd3);
    after_rsp("t4");

    // ---------------- 5: reset during TW of a write ----------------
    req_we = 1'b1; req_addr = 16'h0010; req_wdata = 8'h77; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("t5_in_tw", 32'(dbg_state), 32'd3);
    check("t5_wrn_low", 32'(obus_wrn), 32'd0);
    #2 rstn = 1'b0;
    #1;
    check("t5_wrn_async", 32'(obus_wrn), 32'd1);
    check("t5_state_async", 32'(dbg_state), 32'd0);
    check("t5_no_rsp_now", 32'(rsp_valid), 32'd0);
    step();
    rstn = 1'b1; stuck = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    check("t5_no_rsp_after", 32'(seen), 32'd0);
    xact(1'b1, 16'h0010, 8'h5A, 1'b0, lat, rdl, wrl, err, rd);
    check("t5w_latency", 32'(lat), 32'd4);
    check("t5w_err", 32'(err), 32'd0);
    after_rsp("t5w");
    xact(1'b0, 16'h0010, 8'h00, 1'b0, lat, rdl, wrl, err, rd);
    check("t5r_rdata", 32'(rd), 32'h5A);
    after_rsp("t5r");

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
